// File: rtl/signed_add_arbiter.sv
// -----------------------------------------------------------------------------
// signed_add_arbiter
//
// One 8-bit two's-complement adder with signed-overflow detection, shared
// among NUM_REQ requesters. A round-robin arbiter picks one requester per
// cycle. Its operands are added and the result is registered into a one-entry
// output slot. The slot has its own valid/ready handshake.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   req_valid     in   [NUM_REQ]        requester i has operands pending
//   req_a         in   [NUM_REQ*WIDTH]  operand a of requester i at [i*WIDTH +: WIDTH]
//   req_b         in   [NUM_REQ*WIDTH]  operand b of requester i at [i*WIDTH +: WIDTH]
//   req_ready     out  [NUM_REQ]        one-hot or zero; operands of i taken this cycle
//   rsp_valid     out                   output slot holds a result
//   rsp_ready     in                    consumer takes the result this cycle
//   rsp_sum       out  [WIDTH]          a + b truncated to WIDTH bits
//   rsp_overflow  out                   signed overflow of that addition
//   rsp_id        out  [IDW]            index of the requester that produced rsp_sum
//   ovf_count     out  [8]              saturating count of accepted overflowing ops
// -----------------------------------------------------------------------------
module signed_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int IDW     = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_sum,
   output logic                       rsp_overflow,
   output logic [IDW-1:0]             rsp_id,
   output logic [7:0]                 ovf_count
);

   // Output slot states.
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);
   localparam logic [7:0]     CNT_MAX  = 8'hFF;

   logic [0:0]         slot_state;
   logic [IDW-1:0]     ptr;

   logic               grant_found;
   logic [IDW-1:0]     grant_idx;
   logic [NUM_REQ-1:0] grant_vec;
   logic               can_accept;
   logic               accept;
   logic [IDW-1:0]     ptr_after_grant;

   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   sum;
   logic               sum_ovf;

   // ---------------------------------------------------------------------------
   // Round-robin arbitration. The scan starts at ptr and wraps from NUM_REQ-1
   // back to 0. The first requester with valid set wins.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(idx);
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      for (int i = 0; i < NUM_REQ; i++)
         grant_vec[i] = grant_found && (grant_idx == IDW'(i));
   end

   // The slot can take a new result when it is empty. It can also take one
   // when it is being drained in this same cycle, which allows one op per cycle.
   assign can_accept = (slot_state == EMPTY) || rsp_ready;

   // Reset masks the handshake so that no requester thinks it was served
   // while the slot is being cleared.
   assign req_ready = grant_vec & {NUM_REQ{can_accept && !reset}};
   assign accept    = |req_ready;

   assign ptr_after_grant = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDW'(1);

   // ---------------------------------------------------------------------------
   // Datapath: the operand mux feeds the shared adder.
   // ---------------------------------------------------------------------------
   assign op_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
   assign op_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];
   assign sum  = op_a + op_b;

   // Signed overflow: the operands have the same sign and the sum has the other.
   assign sum_ovf = (~op_a[WIDTH-1] & ~op_b[WIDTH-1] &  sum[WIDTH-1]) |
                    ( op_a[WIDTH-1] &  op_b[WIDTH-1] & ~sum[WIDTH-1]);

   // ---------------------------------------------------------------------------
   // Slot FSM, result registers, arbitration pointer and overflow counter.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments. Every flop then
      // samples values from before the edge, whatever the statement order.
      if (reset) begin
         // NOTE: every register here is control or result state with a defined
         // reset value. There is no storage array to leave unreset.
         slot_state   <= EMPTY;
         ptr          <= '0;
         rsp_sum      <= '0;
         rsp_overflow <= 1'b0;
         rsp_id       <= '0;
         ovf_count    <= '0;
      end else begin
         case (slot_state)
            EMPTY: if (accept)                 slot_state <= FULL;
            FULL:  if (rsp_ready && !accept)   slot_state <= EMPTY;
            default:                           slot_state <= EMPTY;
         endcase

         // Results change only on an accept. While the slot is full and stalled,
         // no accept can happen, so the outputs stay stable.
         if (accept) begin
            rsp_sum      <= sum;
            rsp_overflow <= sum_ovf;
            rsp_id       <= grant_idx;
            ptr          <= ptr_after_grant;
            if (sum_ovf && (ovf_count != CNT_MAX))
               ovf_count <= ovf_count + 8'd1;
         end
      end
   end

   assign rsp_valid = (slot_state == FULL);

endmodule
